// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the FSM encoding and the grant index width helper.
package uart_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_ACK,
      WAIT_DONE
   } arb_state_e;

   localparam int NREQ_DEF        = 4;
   localparam int MAX_BURST_DEF   = 4;
   localparam int ACK_TIMEOUT_DEF = 15;

   function automatic int gidx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority requester search, purely combinational.
// Scans upward from last_grant+1 and wraps at NREQ.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int GW   = 2
) (
   input  logic [NREQ-1:0] req_valid,
   input  logic [GW-1:0]   last_grant,
   output logic [GW-1:0]   winner,
   output logic            any
);

   int idx;

   // Walk from lowest to highest priority so the nearest hit wins.
   always_comb begin
      winner = '0;
      any    = 1'b0;
      idx    = 0;
      for (int i = NREQ; i >= 1; i--) begin
         idx = (int'(last_grant) + i) % NREQ;
         if ((req_valid & (NREQ'(1) << idx)) != '0) begin
            winner = GW'(idx);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NREQ requesters into one UART TX.
// Grants hold for a burst, bounded by req_last, MAX_BURST or enable.
module uart_tx_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int NREQ        = NREQ_DEF,
   parameter int MAX_BURST   = MAX_BURST_DEF,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic                      PCLK,
   input  logic                      PRESETn,
   input  logic                      enable,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*8-1:0]         req_data,
   input  logic [NREQ-1:0]           req_last,
   output logic [NREQ-1:0]           req_ready,
   output logic                      tx_en,
   output logic [7:0]                tx_data,
   input  logic                      tx_busy,
   output logic                      grant_active,
   output logic [gidx_w(NREQ)-1:0]   grant_id,
   output logic                      err_timeout
);

   localparam int GW = gidx_w(NREQ);
   localparam int WW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [3:0]    BMAX     = 4'(MAX_BURST);
   localparam logic [WW-1:0] TMO_LAST = WW'(ACK_TIMEOUT - 1);

   arb_state_e      state_q, state_d;
   logic [GW-1:0]   grant_id_q, grant_id_d;
   logic [GW-1:0]   last_grant_q, last_grant_d;
   logic            grant_active_q, grant_active_d;
   logic [3:0]      burst_cnt_q, burst_cnt_d;
   logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
   logic            last_flag_q, last_flag_d;
   logic            err_q, err_d;
   logic            tx_en_q, tx_en_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic [NREQ-1:0] req_ready_q, req_ready_d;

   logic [GW-1:0]   pick_winner;
   logic            pick_any;
   logic [NREQ-1:0] gnt_oh;
   logic            own_valid, own_last;
   logic            do_grant, do_send, do_rel, rel_done, tmo;

   rr_pick #(
      .NREQ (NREQ),
      .GW   (GW)
   ) u_pick (
      .req_valid  (req_valid),
      .last_grant (last_grant_q),
      .winner     (pick_winner),
      .any        (pick_any)
   );

   assign gnt_oh    = NREQ'(1) << grant_id_q;
   assign own_valid = |(req_valid & gnt_oh);
   assign own_last  = |(req_last & gnt_oh);
   assign do_grant  = (state_q == IDLE) && enable && pick_any;
   assign do_send   = (state_q == SEND) && own_valid && !tx_busy;
   assign rel_done  = last_flag_q || (burst_cnt_q >= BMAX)
                      || !enable || !own_valid;
   assign do_rel    = ((state_q == SEND) && !own_valid)
                      || ((state_q == WAIT_DONE) && !tx_busy && rel_done);
   assign tmo       = (state_q == WAIT_ACK) && !tx_busy
                      && (wait_cnt_q == TMO_LAST);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (do_grant) state_d = SEND;
         SEND: begin
            if (!own_valid)    state_d = IDLE;
            else if (!tx_busy) state_d = WAIT_ACK;
         end
         WAIT_ACK:  if (tx_busy || tmo) state_d = WAIT_DONE;
         WAIT_DONE: if (!tx_busy) state_d = rel_done ? IDLE : SEND;
      endcase
   end

   always_comb begin
      grant_id_d     = grant_id_q;
      last_grant_d   = last_grant_q;
      grant_active_d = grant_active_q;
      burst_cnt_d    = burst_cnt_q;
      wait_cnt_d     = wait_cnt_q;
      last_flag_d    = last_flag_q;
      err_d          = err_q;
      tx_en_d        = 1'b0;
      tx_data_d      = tx_data_q;
      req_ready_d    = '0;
      if (do_grant) begin
         grant_id_d     = pick_winner;
         grant_active_d = 1'b1;
         burst_cnt_d    = '0;
      end
      if (do_send) begin
         tx_en_d     = 1'b1;
         tx_data_d   = 8'(req_data >> {grant_id_q, 3'b000});
         req_ready_d = gnt_oh;
         last_flag_d = own_last;
         burst_cnt_d = (burst_cnt_q >= BMAX) ? burst_cnt_q
                                             : burst_cnt_q + 4'd1;
         wait_cnt_d  = '0;
      end
      if ((state_q == WAIT_ACK) && !tx_busy) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
         if (tmo) err_d = 1'b1;
      end
      if (do_rel) begin
         last_grant_d   = grant_id_q;
         grant_active_d = 1'b0;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         grant_id_q     <= '0;
         last_grant_q   <= GW'(NREQ - 1);
         grant_active_q <= 1'b0;
         burst_cnt_q    <= '0;
         wait_cnt_q     <= '0;
         last_flag_q    <= 1'b0;
         err_q          <= 1'b0;
         tx_en_q        <= 1'b0;
         tx_data_q      <= '0;
         req_ready_q    <= '0;
      end else begin
         grant_id_q     <= grant_id_d;
         last_grant_q   <= last_grant_d;
         grant_active_q <= grant_active_d;
         burst_cnt_q    <= burst_cnt_d;
         wait_cnt_q     <= wait_cnt_d;
         last_flag_q    <= last_flag_d;
         err_q          <= err_d;
         tx_en_q        <= tx_en_d;
         tx_data_q      <= tx_data_d;
         req_ready_q    <= req_ready_d;
      end
   end

   assign req_ready    = req_ready_q;
   assign tx_en        = tx_en_q;
   assign tx_data      = tx_data_q;
   assign grant_active = grant_active_q;
   assign grant_id     = grant_id_q;
   assign err_timeout  = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with requester and transmitter models.
// Expected values are hand-derived cycle positions, grant orders and bytes.
module tb_uart_tx_arbiter;

   localparam int BUSY_LEN = 10;

   logic        PCLK;
   logic        PRESETn;
   logic        enable;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        tx_en;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        grant_active;
   logic [1:0]  grant_id;
   logic        err_timeout;

   uart_tx_arbiter dut (
      .PCLK         (PCLK),
      .PRESETn      (PRESETn),
      .enable       (enable),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .tx_en        (tx_en),
      .tx_data      (tx_data),
      .tx_busy      (tx_busy),
      .grant_active (grant_active),
      .grant_id     (grant_id),
      .err_timeout  (err_timeout)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   int         n_chk = 0;
   int         n_pass = 0;
   int         rem [4];
   int         sent [4];
   logic [7:0] base [4];
   logic [3:0] last_all;
   bit         model_on;
   int         busy_cnt;
   int         cyc;
   int         n_en;
   logic [1:0] glog [16];
   logic [7:0] dlog [16];
   int         en_cyc [16];
   int         rdy_cnt [4];
   int         viol;
   int         err_cyc;
   int         ga_fall;
   bit         ga_seen;
   logic [7:0] prev_data;
   int         c0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         req_valid[i]      = (rem[i] != 0);
         req_last[i]       = last_all[i] || (rem[i] == 1);
         req_data[8*i +: 8] = base[i] + 8'(sent[i]);
      end
      tx_busy = model_on && (busy_cnt != 0);
   endtask

   task automatic clear_logs();
      n_en    = 0;
      err_cyc = -1;
      ga_fall = -1;
      ga_seen = 1'b0;
      for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 4; i++) begin
         rem[i]  = 0;
         sent[i] = 0;
      end
      last_all = 4'h0;
      busy_cnt = 0;
      drive();
   endtask

   task automatic tick();
      logic [3:0] rdy;
      logic       ten;
      @(negedge PCLK);
      if (tx_en) begin
         if (n_en < 16) begin
            glog[n_en]   = grant_id;
            dlog[n_en]   = tx_data;
            en_cyc[n_en] = cyc;
         end
         n_en++;
         if (req_ready == 4'h0) viol++;
      end
      if (req_ready != 4'h0)
         if (req_ready != (4'b0001 << grant_id) || !grant_active) viol++;
      for (int i = 0; i < 4; i++) if (req_ready[i]) rdy_cnt[i]++;
      if (tx_busy && tx_data !== prev_data) viol++;
      prev_data = tx_data;
      if (err_timeout && err_cyc < 0) err_cyc = cyc;
      if (grant_active) ga_seen = 1'b1;
      else if (ga_seen && ga_fall < 0) ga_fall = cyc;
      rdy = req_ready;
      ten = tx_en;
      @(posedge PCLK);
      #1;
      for (int i = 0; i < 4; i++)
         if (rdy[i] && rem[i] > 0) begin
            rem[i]--;
            sent[i]++;
         end
      if (ten) busy_cnt = BUSY_LEN;
      else if (busy_cnt > 0) busy_cnt--;
      drive();
      cyc++;
   endtask

   task automatic do_reset();
      @(posedge PCLK);
      #1;
      PRESETn = 1'b0;
      enable  = 1'b0;
      clear_model();
      tick();
      tick();
      PRESETn = 1'b1;
      clear_logs();
   endtask

   initial begin
      PRESETn  = 1'b1;
      enable   = 1'b0;
      model_on = 1'b1;
      cyc      = 0;
      viol     = 0;
      prev_data = 8'h00;
      for (int i = 0; i < 4; i++) base[i] = 8'h00;
      clear_model();
      clear_logs();
      #2 PRESETn = 1'b0;
      #1;
      chk("rst_txen",  32'(tx_en), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_gact",  32'(grant_active), 0);
      chk("rst_gid",   32'(grant_id), 0);
      chk("rst_err",   32'(err_timeout), 0);
      chk("rst_data",  32'(tx_data), 0);
      tick();
      tick();
      PRESETn = 1'b1;
      clear_logs();

      // single byte from requester 0
      base[0] = 8'hA5;
      rem[0]  = 1;
      enable  = 1'b1;
      drive();
      c0 = cyc;
      repeat (30) tick();
      chk("single_cnt",  n_en, 1);
      chk("single_lat",  en_cyc[0] - c0, 2);
      chk("single_data", 32'(dlog[0]), 32'h A5);
      chk("single_gid",  32'(glog[0]), 0);
      chk("single_rdy",  rdy_cnt[0], 1);
      chk("single_rel",  ga_fall - en_cyc[0], 12);

      // fairness across four always-valid requesters
      do_reset();
      for (int i = 0; i < 4; i++) begin
         base[i] = 8'(16 * i + 1);
         rem[i]  = 100;
      end
      last_all = 4'hF;
      enable   = 1'b1;
      drive();
      repeat (66) tick();
      chk("fair_cnt", n_en, 5);
      chk("fair_g0", 32'(glog[0]), 0);
      chk("fair_g1", 32'(glog[1]), 1);
      chk("fair_g2", 32'(glog[2]), 2);
      chk("fair_g3", 32'(glog[3]), 3);
      chk("fair_g4", 32'(glog[4]), 0);
      chk("fair_d1", 32'(dlog[1]), 32'h11);
      chk("fair_d4", 32'(dlog[4]), 32'h02);
      chk("fair_rdy0", rdy_cnt[0], 2);
      chk("fair_rdy3", rdy_cnt[3], 1);

      // burst cap on requester 2, then requester 3 joins
      do_reset();
      base[2] = 8'h30;
      rem[2]  = 6;
      enable  = 1'b1;
      drive();
      for (int k = 0; k < 200 && n_en < 4; k++) tick();
      base[3] = 8'hC0;
      rem[3]  = 1;
      drive();
      repeat (35) tick();
      chk("burst_cnt", n_en, 6);
      chk("burst_gap", en_cyc[1] - en_cyc[0], 13);
      chk("burst_g3", 32'(glog[3]), 2);
      chk("burst_d3", 32'(dlog[3]), 32'h33);
      chk("burst_g4", 32'(glog[4]), 3);
      chk("burst_d4", 32'(dlog[4]), 32'hC0);
      chk("burst_g5", 32'(glog[5]), 2);
      chk("burst_d5", 32'(dlog[5]), 32'h34);

      // ack timeout with a dead transmitter
      do_reset();
      model_on = 1'b0;
      base[1]  = 8'h5A;
      rem[1]   = 1;
      enable   = 1'b1;
      drive();
      repeat (40) tick();
      chk("tmo_cnt",  n_en, 1);
      chk("tmo_gid",  32'(glog[0]), 1);
      chk("tmo_time", err_cyc - en_cyc[0], 15);
      chk("tmo_rel",  ga_fall - en_cyc[0], 16);
      chk("tmo_sticky", 32'(err_timeout), 1);
      chk("tmo_idle", 32'(grant_active), 0);
      model_on = 1'b1;

      // enable drop during the second byte
      do_reset();
      base[0] = 8'h40;
      rem[0]  = 4;
      enable  = 1'b1;
      drive();
      for (int k = 0; k < 200 && n_en < 2; k++) tick();
      enable = 1'b0;
      repeat (40) tick();
      chk("endrop_cnt", n_en, 2);
      chk("endrop_d1",  32'(dlog[1]), 32'h41);
      chk("endrop_rdy", rdy_cnt[0], 2);
      chk("endrop_rel", ga_fall - en_cyc[1], 12);

      // reset while the transmitter is busy mid-burst
      do_reset();
      base[3] = 8'hD0;
      rem[3]  = 4;
      enable  = 1'b1;
      drive();
      for (int k = 0; k < 200 && n_en < 1; k++) tick();
      repeat (5) tick();
      chk("mid_gact", 32'(grant_active), 1);
      PRESETn = 1'b0;
      clear_model();
      #1;
      chk("mid_txen",  32'(tx_en), 0);
      chk("mid_ready", 32'(req_ready), 0);
      chk("mid_gact0", 32'(grant_active), 0);
      chk("mid_gid",   32'(grant_id), 0);
      chk("mid_data",  32'(tx_data), 0);
      prev_data = 8'h00;
      base[0] = 8'h11;
      base[3] = 8'h33;
      rem[0]  = 1;
      rem[3]  = 1;
      drive();
      clear_logs();
      repeat (3) tick();
      chk("mid_quiet", n_en + rdy_cnt[0] + rdy_cnt[3], 0);
      PRESETn = 1'b1;
      c0 = cyc;
      repeat (20) tick();
      chk("mid_lat", en_cyc[0] - c0, 2);
      chk("mid_g0",  32'(glog[0]), 0);
      chk("mid_d0",  32'(dlog[0]), 32'h11);
      chk("mid_g1",  32'(glog[1]), 3);

      chk("invariants", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, is the number of requesters (2..8).
REQ-002 Parameter MAX_BURST, default 4, is the maximum number of bytes per grant (1..15).
REQ-003 Parameter ACK_TIMEOUT, default 15, is the maximum number of cycles to wait for tx_busy to rise after tx_en.
REQ-004 Port PCLK, input, 1 bit, is the single clock; all state is updated on its rising edge.
REQ-005 Port PRESETn, input, 1 bit, is the asynchronous, active-low reset.
REQ-006 Port enable, input, 1 bit, allows new grants when high.
REQ-007 Port req_valid, input, NREQ bits, gives a per-requester byte-available flag.
REQ-008 Port req_data, input, NREQ*8 bits, holds the byte for requester i in bits [8i+7:8i].
REQ-009 Port req_last, input, NREQ bits, marks the current byte as the final byte of the requester's burst.
REQ-010 Port req_ready, output, NREQ bits, is a one-hot, one-cycle pulse that acknowledges the byte consumed.
REQ-011 Port tx_en, output, 1 bit, is a one-cycle start pulse to the UART transmitter.
REQ-012 Port tx_data, output, 8 bits, is the byte presented with tx_en and held until the next load.
REQ-013 Port tx_busy, input, 1 bit, is high while the transmitter is shifting.
REQ-014 Port grant_active, output, 1 bit, is high while a requester owns the transmitter.
REQ-015 Port grant_id, output, clog2(NREQ) bits, identifies the current owner.
REQ-016 Port err_timeout, output, 1 bit, is a sticky flag that tx_busy never rose; it is cleared only by reset.

Function
REQ-017 The FSM SHALL have the states IDLE, SEND, WAIT_ACK and WAIT_DONE.
REQ-018 In IDLE, when enable=1 and req_valid is nonzero, the block SHALL select the first valid requester searching upward from last_grant+1 (mod NREQ), latch grant_id, set grant_active=1, clear burst_cnt, and go to SEND.
REQ-019 In SEND, when tx_busy=0, the block SHALL for exactly one cycle assert tx_en=1, drive tx_data=req_data[grant_id] and req_ready[grant_id]=1, latch req_last into last_flag, increment burst_cnt, clear wait_cnt, and go to WAIT_ACK.
REQ-020 In SEND, when tx_busy=1, the block SHALL wait with tx_en=0.
REQ-021 In SEND, when req_valid[grant_id]=0, the block SHALL release the grant.
REQ-022 In WAIT_ACK, the block SHALL go to WAIT_DONE on tx_busy=1; otherwise it SHALL increment wait_cnt.
REQ-023 In WAIT_ACK, when wait_cnt reaches ACK_TIMEOUT, the block SHALL set err_timeout and go to WAIT_DONE.
REQ-024 In WAIT_DONE, on tx_busy=0 the block SHALL release if last_flag=1, burst_cnt=MAX_BURST, enable=0, or req_valid[grant_id]=0; otherwise it SHALL return to SEND.
REQ-025 Release SHALL set last_grant=grant_id and grant_active=0, and return to IDLE; a new grant SHALL NOT be issued in the release cycle.
REQ-026 Minimum IDLE-to-tx_en latency SHALL be 2 cycles (grant cycle plus SEND cycle).
REQ-027 req_ready SHALL never be high for more than one bit, nor for a requester that is not granted.
REQ-028 Deasserting enable mid-burst SHALL complete the byte in flight and release at its end; no byte SHALL be truncated.
REQ-029 burst_cnt SHALL be 4 bits and SHALL saturate at MAX_BURST.
REQ-030 last_grant SHALL wrap from NREQ-1 to 0.
REQ-031 tx_data SHALL NOT change while tx_busy=1.

Reset
REQ-032 On PRESETn=0, asynchronously, the FSM SHALL enter IDLE.
REQ-033 On PRESETn=0, tx_en, req_ready, grant_active, grant_id, err_timeout, tx_data, burst_cnt and wait_cnt SHALL all be 0.
REQ-034 On PRESETn=0, last_grant SHALL be NREQ-1 so that requester 0 has first priority.
REQ-035 Reset asserted mid-burst SHALL abandon the burst with no further tx_en or req_ready pulses.

Structure
REQ-036 Package uart_ctrl_pkg SHALL hold the FSM state enum, the default NREQ, MAX_BURST and ACK_TIMEOUT values, and the grant index width function.
REQ-037 The rotating-priority search SHALL be a combinational sub-module rr_pick (inputs req_valid and last_grant; outputs winner and any) with no state.

Verification
REQ-038 Single byte: req_valid=0001, req_data[0]=8'hA5, req_last=1, tx_busy model 10 cycles -> one tx_en with tx_data=A5, req_ready=0001 in the same cycle, release after tx_busy falls.
REQ-039 Fairness: all four requesters valid continuously with req_last=1 -> grant order 0,1,2,3,0; each req_ready pulses once per grant.
REQ-040 Burst cap: requester 2 valid with 6 bytes, req_last=0, MAX_BURST=4 -> exactly 4 tx_en under grant_id=2, release, then requester 2 regranted only if no other requester is valid.
REQ-041 Timeout: tx_busy held 0 -> err_timeout=1 exactly ACK_TIMEOUT cycles after tx_en, FSM reaches IDLE, err_timeout stays set.
REQ-042 Enable drop: enable=0 during the second byte of a 4-byte burst -> the second byte completes, release occurs, no third tx_en.
REQ-043 Reset mid-burst: PRESETn pulsed low in WAIT_DONE -> all outputs 0 immediately, and after reset requester 0 wins when requesters 0 and 3 are both valid.
